// File: rtl/mem_wb.sv
// MEM->WB pipeline register with load-data alignment and a retired-instruction counter.
// Optional sub-word loads (byte/half) are enabled by defining MEM_WB_SUBWORD_LOAD_EN.
module mem_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [1:0]  stall,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        mem_load,
  input  logic [1:0]  mem_ldsz,
  input  logic        mem_ldsign,
  input  logic [1:0]  mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        wb_misalign,
  output logic [31:0] retired
);

  logic [4:0]  wb_wd_q, wb_wd_d;
  logic        wb_wreg_q, wb_wreg_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic        wb_misalign_q, wb_misalign_d;
  logic [31:0] retired_q, retired_d;

  logic [31:0] ld_data_s;
  logic        ld_misalign_s;

`ifdef MEM_WB_SUBWORD_LOAD_EN
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Big-endian lane selection and extension of the loaded word.
  always_comb begin
    ld_data_s     = 32'd0;
    ld_misalign_s = 1'b0;
    byte_s        = 8'd0;
    half_s        = 16'd0;
    case (mem_ldsz)
      2'b00: begin
        ld_data_s     = mem_rdata;
        ld_misalign_s = (mem_addr != 2'b00);
      end
      2'b01: begin
        half_s        = mem_addr[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        ld_data_s     = {{16{mem_ldsign & half_s[15]}}, half_s};
        ld_misalign_s = mem_addr[0];
      end
      2'b10: begin
        case (mem_addr)
          2'b00:   byte_s = mem_rdata[31:24];
          2'b01:   byte_s = mem_rdata[23:16];
          2'b10:   byte_s = mem_rdata[15:8];
          default: byte_s = mem_rdata[7:0];
        endcase
        ld_data_s = {{24{mem_ldsign & byte_s[7]}}, byte_s};
      end
      default: ld_misalign_s = 1'b1;
    endcase
  end
`else
  logic unused_ldsign_s;
  assign unused_ldsign_s = mem_ldsign;

  // Only aligned word loads are supported; every sub-word size faults.
  always_comb begin
    ld_data_s     = 32'd0;
    ld_misalign_s = 1'b0;
    case (mem_ldsz)
      2'b00: begin
        ld_data_s     = mem_rdata;
        ld_misalign_s = (mem_addr != 2'b00);
      end
      default: ld_misalign_s = 1'b1;
    endcase
  end
`endif

  // Next-state selection: flush, hold, bubble or capture, in that priority.
  always_comb begin
    wb_wd_d       = wb_wd_q;
    wb_wreg_d     = wb_wreg_q;
    wb_wdata_d    = wb_wdata_q;
    wb_misalign_d = 1'b0;
    retired_d     = retired_q;
    if (flush || (stall == 2'b01)) begin
      wb_wd_d    = 5'd0;
      wb_wreg_d  = 1'b0;
      wb_wdata_d = 32'd0;
    end else if (stall == 2'b11) begin
      wb_misalign_d = 1'b0;
    end else if (mem_load && ld_misalign_s) begin
      wb_wd_d       = 5'd0;
      wb_wreg_d     = 1'b0;
      wb_wdata_d    = 32'd0;
      wb_misalign_d = 1'b1;
    end else begin
      wb_wd_d    = mem_wd;
      wb_wreg_d  = mem_wreg;
      wb_wdata_d = mem_load ? ld_data_s : mem_wdata;
      if (mem_wreg && (mem_wd != 5'd0)) begin
        retired_d = retired_q + 32'd1;
      end else begin
        retired_d = retired_q;
      end
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_wd_q       <= 5'd0;
      wb_wreg_q     <= 1'b0;
      wb_wdata_q    <= 32'd0;
      wb_misalign_q <= 1'b0;
      retired_q     <= 32'd0;
    end else begin
      wb_wd_q       <= wb_wd_d;
      wb_wreg_q     <= wb_wreg_d;
      wb_wdata_q    <= wb_wdata_d;
      wb_misalign_q <= wb_misalign_d;
      retired_q     <= retired_d;
    end
  end

  assign wb_wd       = wb_wd_q;
  assign wb_wreg     = wb_wreg_q;
  assign wb_wdata    = wb_wdata_q;
  assign wb_misalign = wb_misalign_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural model of the writeback register.
module tb_mem_wb;

`ifdef MEM_WB_SUBWORD_LOAD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        clk, rst, flush;
  logic [1:0]  stall;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_load;
  logic [1:0]  mem_ldsz;
  logic        mem_ldsign;
  logic [1:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_misalign;
  logic [31:0] retired;

  mem_wb dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_load(mem_load), .mem_ldsz(mem_ldsz), .mem_ldsign(mem_ldsign),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_misalign(wb_misalign), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the load result is picked out of a byte array by address.
  function automatic logic model_bad(input logic ld, input logic [1:0] sz, input logic [1:0] a);
    if (!ld) return 1'b0;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd0) return a != 2'd0;
    if (!SUB) return 1'b1;
    if (sz == 2'd1) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_data(input logic ld, input logic [1:0] sz,
                                             input logic sgn, input logic [1:0] a,
                                             input logic [31:0] rd, input logic [31:0] wd);
    logic [7:0] b [4];
    logic [7:0] v8;
    logic [15:0] v16;
    for (int k = 0; k < 4; k++) b[k] = rd[31 - 8*k -: 8];
    if (!ld || sz == 2'd0) return ld ? rd : wd;
    if (sz == 2'd2) begin
      v8 = b[a];
      return sgn ? 32'($signed(v8)) : 32'(v8);
    end
    v16 = {b[a], b[a + 2'd1]};
    return sgn ? 32'($signed(v16)) : 32'(v16);
  endfunction

  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_wdata;
  logic        m_mis;
  logic [31:0] m_ret;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wd <= 5'd0; m_wreg <= 1'b0; m_wdata <= 32'd0; m_mis <= 1'b0; m_ret <= 32'd0;
    end else if (flush || stall == 2'b01) begin
      m_wd <= 5'd0; m_wreg <= 1'b0; m_wdata <= 32'd0; m_mis <= 1'b0;
    end else if (stall == 2'b11) begin
      m_mis <= 1'b0;
    end else if (model_bad(mem_load, mem_ldsz, mem_addr)) begin
      m_wd <= 5'd0; m_wreg <= 1'b0; m_wdata <= 32'd0; m_mis <= 1'b1;
    end else begin
      m_wd    <= mem_wd;
      m_wreg  <= mem_wreg;
      m_wdata <= model_data(mem_load, mem_ldsz, mem_ldsign, mem_addr, mem_rdata, mem_wdata);
      m_mis   <= 1'b0;
      m_ret   <= m_ret + ((mem_wreg && mem_wd != 5'd0) ? 32'd1 : 32'd0);
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      chk("cmp_wd", 32'(wb_wd), 32'(m_wd));
      chk("cmp_wreg", 32'(wb_wreg), 32'(m_wreg));
      chk("cmp_wdata", wb_wdata, m_wdata);
      chk("cmp_misalign", 32'(wb_misalign), 32'(m_mis));
      chk("cmp_retired", retired, m_ret);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] wd, input logic wreg,
                            input logic [31:0] wdata, input logic mis, input logic [31:0] ret);
    chk({tag, "_wd"}, 32'(wb_wd), 32'(wd));
    chk({tag, "_wreg"}, 32'(wb_wreg), 32'(wreg));
    chk({tag, "_wdata"}, wb_wdata, wdata);
    chk({tag, "_misalign"}, 32'(wb_misalign), 32'(mis));
    chk({tag, "_retired"}, retired, ret);
    chk({tag, "_model_wdata"}, m_wdata, wdata);
    chk({tag, "_model_retired"}, m_ret, ret);
  endtask

  task automatic set_op(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic ld, input logic [1:0] sz, input logic sgn,
                        input logic [1:0] a, input logic [31:0] rd);
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata; mem_load = ld;
    mem_ldsz = sz; mem_ldsign = sgn; mem_addr = a; mem_rdata = rd;
  endtask

  logic [31:0] r;

  initial begin
    rst = 1'b0; flush = 1'b0; stall = 2'b00;
    set_op(5'd0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0);
    #1 rst = 1'b1;
    #1 expect_out("reset", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #10 rst = 1'b0;
    run_cmp = 1'b1;

    set_op(5'd5, 1'b1, 32'h12345678, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0);
    step();
    expect_out("nonload", 5'd5, 1'b1, 32'h12345678, 1'b0, 32'd1);

    r = SUB ? 32'd2 : 32'd1;
    set_op(5'd7, 1'b1, 32'd0, 1'b1, 2'b10, 1'b1, 2'b10, 32'h11228344);
    step();
    if (SUB) expect_out("byte_sx", 5'd7, 1'b1, 32'hFFFFFF83, 1'b0, r);
    else     expect_out("byte_sx", 5'd0, 1'b0, 32'd0, 1'b1, r);

    r = SUB ? 32'd3 : 32'd1;
    mem_ldsign = 1'b0;
    step();
    if (SUB) expect_out("byte_zx", 5'd7, 1'b1, 32'h00000083, 1'b0, r);
    else     expect_out("byte_zx", 5'd0, 1'b0, 32'd0, 1'b1, r);

    r = SUB ? 32'd4 : 32'd1;
    mem_ldsign = 1'b1; mem_ldsz = 2'b01;
    step();
    if (SUB) expect_out("half_sx", 5'd7, 1'b1, 32'hFFFF8344, 1'b0, r);
    else     expect_out("half_sx", 5'd0, 1'b0, 32'd0, 1'b1, r);

    r = SUB ? 32'd5 : 32'd2;
    set_op(5'd3, 1'b1, 32'h0, 1'b1, 2'b00, 1'b0, 2'b00, 32'hCAFEBABE);
    step();
    expect_out("word_ld", 5'd3, 1'b1, 32'hCAFEBABE, 1'b0, r);

    r = SUB ? 32'd6 : 32'd3;
    set_op(5'd9, 1'b1, 32'hA5A5A5A5, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0);
    step();
    expect_out("pre_stall", 5'd9, 1'b1, 32'hA5A5A5A5, 1'b0, r);
    stall = 2'b11;
    set_op(5'd1, 1'b1, 32'hFFFFFFFF, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("hold", 5'd9, 1'b1, 32'hA5A5A5A5, 1'b0, r);
    end
    stall = 2'b01;
    step();
    expect_out("bubble", 5'd0, 1'b0, 32'd0, 1'b0, r);

    stall = 2'b00;
    set_op(5'd4, 1'b1, 32'd0, 1'b1, 2'b00, 1'b0, 2'b01, 32'h01020304);
    step();
    expect_out("misalign", 5'd0, 1'b0, 32'd0, 1'b1, r);
    stall = 2'b11;
    step();
    expect_out("mis_hold", 5'd0, 1'b0, 32'd0, 1'b0, r);

    stall = 2'b00; flush = 1'b1;
    set_op(5'd6, 1'b1, 32'h77, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0);
    step();
    expect_out("flush", 5'd0, 1'b0, 32'd0, 1'b0, r);
    flush = 1'b0;
    set_op(5'd0, 1'b1, 32'h55, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0);
    step();
    expect_out("wd_zero", 5'd0, 1'b1, 32'h55, 1'b0, r);

    // Reset pulsed mid-cycle while an entry is being held.
    set_op(5'd9, 1'b1, 32'h0BADF00D, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0);
    step();
    stall = 2'b11;
    step();
    expect_out("hold_pre_rst", 5'd9, 1'b1, 32'h0BADF00D, 1'b0, r + 32'd1);
    rst = 1'b1;
    #1 expect_out("rst_pulse", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1 rst = 1'b0;
    step();
    expect_out("hold_post_rst", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    stall = 2'b10;
    set_op(5'd12, 1'b1, 32'h600D, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0);
    step();
    expect_out("stall10_cap", 5'd12, 1'b1, 32'h600D, 1'b0, 32'd1);

    for (int i = 0; i < 80; i++) begin
      flush = ($urandom_range(0, 7) == 0);
      stall = 2'($urandom_range(0, 3));
      set_op(5'($urandom), 1'($urandom), $urandom, 1'($urandom), 2'($urandom),
             1'($urandom), 2'($urandom), $urandom);
      step();
    end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
